// File: rtl/adder_rr_arbiter_pkg.sv
// Shared encodings for the round-robin adder arbiter: response FSM states and requester ids.
package adder_rr_arbiter_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic ID_P0 = 1'b0;
   localparam logic ID_P1 = 1'b1;

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Two request ports and one response port of the shared adder, plus the overflow-event count.
interface adder_rr_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_ovf;
   logic             rsp_id;
   logic [CNT_W-1:0] ovf_count;

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_sum, rsp_ovf, rsp_id, ovf_count
   );

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_sum, rsp_ovf, rsp_id, ovf_count
   );
endinterface

// File: rtl/adder_rr_arbiter_signed_add_ovf.sv
// Combinational two's-complement adder; sum wraps, ovf flags a sign-inconsistent result.
module signed_add_ovf #(
   parameter int WIDTH = 8
) (
   input  logic signed [WIDTH-1:0] i_a,
   input  logic signed [WIDTH-1:0] i_b,
   output logic signed [WIDTH-1:0] o_sum,
   output logic                    o_ovf
);

   assign o_sum = i_a + i_b;
   // Overflow only possible when both operands share a sign and the result flips it.
   assign o_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/adder_rr_arbiter.sv
// One signed adder shared by two requesters via round-robin grant; single-entry registered response.
module adder_rr_arbiter
   import adder_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   adder_rr_arbiter_if.slave bus
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_rr;
   logic signed [WIDTH-1:0] r_sum;
   logic                    r_ovf;
   logic                    r_id;
   logic [CNT_W-1:0]        r_cnt;

   logic                    w_grant;
   logic                    w_can_accept;
   logic                    w_accept;
   logic signed [WIDTH-1:0] w_a;
   logic signed [WIDTH-1:0] w_b;
   logic signed [WIDTH-1:0] w_sum;
   logic                    w_ovf;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // A lone requester always wins; contention is settled by the rr pointer.
   always_comb begin
      w_grant = ID_P0;
      if (bus.req0_valid && bus.req1_valid) begin
         w_grant = r_rr;
      end else if (bus.req1_valid) begin
         w_grant = ID_P1;
      end
   end

   assign w_can_accept   = (r_state == ST_EMPTY) || bus.rsp_ready;
   assign w_accept       = w_can_accept && (bus.req0_valid || bus.req1_valid);
   assign bus.req0_ready = w_accept && (w_grant == ID_P0);
   assign bus.req1_ready = w_accept && (w_grant == ID_P1);

   assign w_a = (w_grant == ID_P1) ? $signed(bus.req1_a) : $signed(bus.req0_a);
   assign w_b = (w_grant == ID_P1) ? $signed(bus.req1_b) : $signed(bus.req0_b);

   signed_add_ovf #(
      .WIDTH (WIDTH)
   ) u_add (
      .i_a   (w_a),
      .i_b   (w_b),
      .o_sum (w_sum),
      .o_ovf (w_ovf)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
         ST_FULL:  if (bus.rsp_ready && !w_accept) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_rr    <= ID_P0;
         r_sum   <= '0;
         r_ovf   <= 1'b0;
         r_id    <= ID_P0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_sum <= w_sum;
            r_ovf <= w_ovf;
            r_id  <= w_grant;
            r_rr  <= ~w_grant;
            if (w_ovf) r_cnt <= sat_inc(r_cnt);
         end
      end
   end

   assign bus.rsp_valid = (r_state == ST_FULL);
   assign bus.rsp_sum   = r_sum;
   assign bus.rsp_ovf   = r_ovf;
   assign bus.rsp_id    = r_id;
   assign bus.ovf_count = r_cnt;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized and directed bench for adder_rr_arbiter against a behavioural reference model.
module tb_adder_rr_arbiter;
   localparam int WIDTH = 8;
   localparam int CNT_W = 2;
   localparam int CMAX  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   cmp_en = 1'b0;

   adder_rr_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

   adder_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: state as it will be after the coming rising edge.
   bit m_valid = 0;
   bit m_ovf   = 0;
   bit m_id    = 0;
   bit m_rr    = 0;
   int m_sum   = 0;
   int m_cnt   = 0;

   always @(negedge clk) begin
      bit v0, v1, can, g, r0, r1;
      int sa, sb, s, ua, ub;
      v0  = bus.req0_valid;
      v1  = bus.req1_valid;
      can = !m_valid || bus.rsp_ready;
      g   = (v0 && v1) ? m_rr : v1;
      r0  = can && v0 && !g;
      r1  = can && v1 && g;
      if (cmp_en) begin
         check("rsp_valid",  bus.rsp_valid,  m_valid);
         check("rsp_sum",    bus.rsp_sum,    m_sum);
         check("rsp_ovf",    bus.rsp_ovf,    m_ovf);
         check("rsp_id",     bus.rsp_id,     m_id);
         check("ovf_count",  bus.ovf_count,  m_cnt);
         check("req0_ready", bus.req0_ready, r0);
         check("req1_ready", bus.req1_ready, r1);
      end
      if (rst) begin
         m_valid = 0; m_ovf = 0; m_id = 0; m_rr = 0; m_sum = 0; m_cnt = 0;
      end else if (r0 || r1) begin
         ua = g ? int'(bus.req1_a) : int'(bus.req0_a);
         ub = g ? int'(bus.req1_b) : int'(bus.req0_b);
         sa = (ua >= 128) ? ua - 256 : ua;
         sb = (ub >= 128) ? ub - 256 : ub;
         s  = sa + sb;
         m_ovf   = (s > 127) || (s < -128);
         m_sum   = s & 255;
         m_id    = g;
         m_rr    = !g;
         m_valid = 1;
         if (m_ovf && m_cnt < CMAX) m_cnt++;
      end else if (bus.rsp_ready) begin
         m_valid = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   function automatic logic [7:0] pick();
      int k;
      k = $urandom_range(0, 9);
      case (k)
         0: return 8'h7F;
         1: return 8'h80;
         2: return 8'hFF;
         3: return 8'h00;
         4: return 8'h01;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   int  a5[4]  = '{8'h80, 8'hFF, 8'h01, 8'h81};
   int  b5[4]  = '{8'h80, 8'hFF, 8'hFF, 8'h81};
   int  s5[4]  = '{8'h00, 8'hFE, 8'h00, 8'h02};
   int  o5[4]  = '{1, 0, 0, 1};
   int  c6[5]  = '{1, 2, 3, 3, 3};

   initial begin
      bit acc0, acc1;
      idle();
      bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_a = '0; bus.req1_b = '0;
      bus.rsp_ready = 1'b1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      cmp_en = 1'b1;

      // Port 0 only, positive overflow
      bus.req0_valid = 1'b1; bus.req0_a = 8'h7F; bus.req0_b = 8'h01;
      step();
      check("t2_sum", bus.rsp_sum, 8'h80);
      check("t2_ovf", bus.rsp_ovf, 1);
      check("t2_id",  bus.rsp_id, 0);
      check("t2_cnt", bus.ovf_count, 1);

      // Hold a result under back-pressure, then reset it away
      bus.rsp_ready = 1'b0;
      bus.req0_a = 8'h10; bus.req0_b = 8'h20;
      step();
      check("t1_held_valid", bus.rsp_valid, 1);
      check("t1_held_sum", bus.rsp_sum, 8'h80);
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t1_valid", bus.rsp_valid, 0);
      check("t1_cnt", bus.ovf_count, 0);
      check("t1_sum", bus.rsp_sum, 0);

      // Both valid continuously: alternation starts at port 0
      bus.rsp_ready = 1'b1;
      bus.req0_a = 8'd1; bus.req0_b = 8'd2;
      bus.req1_a = 8'd3; bus.req1_b = 8'd4;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t3_id", bus.rsp_id, i % 2);
         check("t3_sum", bus.rsp_sum, (i % 2) ? 7 : 3);
         check("t3_valid", bus.rsp_valid, 1);
      end
      idle();
      step();

      // Back-pressure then release
      bus.req0_valid = 1'b1; bus.req0_a = 8'h05; bus.req0_b = 8'h06;
      step();
      check("t4_first", bus.rsp_sum, 8'h0B);
      bus.rsp_ready = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_a = 8'h20; bus.req1_b = 8'h30;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t4_hold_sum", bus.rsp_sum, 8'h0B);
         check("t4_hold_valid", bus.rsp_valid, 1);
         check("t4_hold_rdy1", bus.req1_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      #1;
      check("t4_release_rdy1", bus.req1_ready, 1);
      step();
      check("t4_new_sum", bus.rsp_sum, 8'h50);
      check("t4_new_id", bus.rsp_id, 1);
      idle();
      step();

      // Arithmetic boundaries on port 1
      for (int i = 0; i < 4; i++) begin
         bus.req1_valid = 1'b1;
         bus.req1_a = 8'(a5[i]); bus.req1_b = 8'(b5[i]);
         step();
         check("t5_sum", bus.rsp_sum, s5[i]);
         check("t5_ovf", bus.rsp_ovf, o5[i]);
         check("t5_id", bus.rsp_id, 1);
      end
      idle();

      // Counter saturation with a 2-bit counter
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = 8'h7F; bus.req0_b = 8'h7F;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t6_cnt", bus.ovf_count, c6[i]);
         check("t6_sum", bus.rsp_sum, 8'hFE);
      end
      idle();
      step();

      // Random traffic; requesters hold operands until accepted
      acc0 = 1'b0;
      acc1 = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!(bus.req0_valid && !acc0)) begin
            bus.req0_valid = ($urandom_range(0, 3) != 0);
            bus.req0_a = pick(); bus.req0_b = pick();
         end
         if (!(bus.req1_valid && !acc1)) begin
            bus.req1_valid = ($urandom_range(0, 3) != 0);
            bus.req1_a = pick(); bus.req1_b = pick();
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 63) == 0);
         #1;
         acc0 = bus.req0_valid && bus.req0_ready;
         acc1 = bus.req1_valid && bus.req1_ready;
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      idle();
      bus.rsp_ready = 1'b1;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
